// File: rtl/debouncer.sv
// Debouncer: accepts a new level on d after HOLD identical samples and emits rise/fall/glitch pulses.
// Optional DEBOUNCER_SYNC_EN inserts a 2-flop synchronizer ahead of the filter.
module debouncer #(
  parameter int unsigned HOLD    = 16,
  parameter int unsigned CNT_W   = 8,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic aclk,
  input  logic arstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic glitch,
  output logic busy
);

  if ((HOLD < 2) || (64'(HOLD) > ((64'd1 << CNT_W) - 64'd1))) begin : g_hold_check
    $error("debouncer: HOLD must be in 2 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StPendHi   = 2'd1,
    StStableHi = 2'd2,
    StPendLo   = 2'd3
  } state_e;

  localparam state_e            RstState = RST_VAL ? StStableHi : StStableLo;
  localparam logic [CNT_W-1:0]  HoldM1   = CNT_W'(HOLD - 1);

  logic d_s;

`ifdef DEBOUNCER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign d_s = sync2_q;
`else
  assign d_s = d;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_q, q_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               glitch_q, glitch_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (d_s) begin
          state_d = StPendHi;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPendHi: begin
        if (!d_s) begin
          state_d  = StStableLo;
          glitch_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == HoldM1) begin
          state_d = StStableHi;
          q_d     = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStableHi: begin
        if (!d_s) begin
          state_d = StPendLo;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPendLo: begin
        if (d_s) begin
          state_d  = StStableHi;
          glitch_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == HoldM1) begin
          state_d = StStableLo;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RstState;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= RstState;
      cnt_q    <= '0;
      q_q      <= RST_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign q      = q_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign glitch = glitch_q;
  assign busy   = (state_q == StPendHi) || (state_q == StPendLo);

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer: a run-length reference model pushes expected outputs per
// driven sample; they are popped and compared one cycle later.
module tb_debouncer;

  localparam int unsigned HOLD    = 16;
  localparam int unsigned CNT_W   = 8;
  localparam bit          RST_VAL = 1'b0;

  logic aclk = 1'b0;
  logic arstn;
  logic d;
  logic q, rise, fall, glitch, busy;

  debouncer #(
    .HOLD   (HOLD),
    .CNT_W  (CNT_W),
    .RST_VAL(RST_VAL)
  ) u_dut (
    .aclk  (aclk),
    .arstn (arstn),
    .d     (d),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .glitch(glitch),
    .busy  (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
    logic glitch;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rise  = 0;
  int   n_fall  = 0;
  int   n_glitch = 0;

  // Reference model: level plus length of the current run of samples that disagree with it.
  logic m_q;
  int   m_run;
  logic m_p1, m_p2;

  task automatic check_eq(input string tag, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q   = RST_VAL;
    m_run = 0;
    m_p1  = RST_VAL;
    m_p2  = RST_VAL;
  endtask

  function automatic exp_t model_edge(input logic din);
    exp_t e;
    logic ds;
`ifdef DEBOUNCER_SYNC_EN
    ds   = m_p2;
    m_p2 = m_p1;
    m_p1 = din;
`else
    ds = din;
`endif
    e = '0;
    if (ds != m_q) begin
      m_run++;
      if (m_run == int'(HOLD)) begin
        m_q    = ds;
        e.rise = ds;
        e.fall = ~ds;
        m_run  = 0;
      end
    end else begin
      e.glitch = (m_run > 0);
      m_run    = 0;
    end
    e.q    = m_q;
    e.busy = (m_run > 0);
    return e;
  endfunction

  // Entered at a negedge; drives one sample, compares after the posedge, returns at next negedge.
  task automatic step(input logic dv);
    exp_t e;
    d = dv;
    exp_q.push_back(model_edge(dv));
    @(posedge aclk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check_eq("q", q, e.q);
      check_eq("rise", rise, e.rise);
      check_eq("fall", fall, e.fall);
      check_eq("glitch", glitch, e.glitch);
      check_eq("busy", busy, e.busy);
      n_rise   += int'(rise);
      n_fall   += int'(fall);
      n_glitch += int'(glitch);
    end
    @(negedge aclk);
  endtask

  task automatic hold(input logic dv, input int n);
    for (int i = 0; i < n; i++) step(dv);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_q"}, q, RST_VAL);
    check_eq({tag, "_rise"}, rise, 1'b0);
    check_eq({tag, "_fall"}, fall, 1'b0);
    check_eq({tag, "_glitch"}, glitch, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int r0, f0, g0;
    logic lvl;
    arstn = 1'b0;
    d     = 1'b1;
    model_reset();
    #100;
    check_reset_outputs("rst");
    @(negedge aclk);
    arstn = 1'b1;

    // Rise after 16 samples, held 30 cycles total.
    r0 = n_rise;
    hold(1'b1, 30);
    check_eq("one_rise", n_rise == r0 + 1, 1'b1);

    // 5-cycle low excursion: glitch, no fall.
    f0 = n_fall; g0 = n_glitch;
    hold(1'b0, 5);
    hold(1'b1, 5);
    check_eq("excursion_no_fall", n_fall == f0, 1'b1);
    check_eq("excursion_glitch", n_glitch == g0 + 1, 1'b1);

    hold(1'b0, 20);
    check_eq("fall_seen", n_fall == f0 + 1, 1'b1);

    // 15 samples short, then a fresh full run.
    r0 = n_rise; g0 = n_glitch;
    hold(1'b1, 15);
    hold(1'b0, 3);
    check_eq("short_no_rise", n_rise == r0, 1'b1);
    check_eq("short_glitch", n_glitch == g0 + 1, 1'b1);
    hold(1'b1, 16);
    check_eq("full_rise", n_rise == r0 + 1, 1'b1);
    hold(1'b0, 20);

    // Reset while pending high with cnt=10.
    hold(1'b1, 10);
    #2;
    arstn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(negedge aclk);
    arstn = 1'b1;
    r0 = n_rise;
    hold(1'b1, 18);
    check_eq("post_rst_rise", n_rise == r0 + 1, 1'b1);
    hold(1'b0, 20);

    // Single-cycle pulse never reaches q.
    r0 = n_rise;
    step(1'b1);
    hold(1'b0, 6);
    check_eq("pulse_no_rise", n_rise == r0, 1'b1);

    // Random run lengths around HOLD.
    lvl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      hold(lvl, int'($urandom_range(1, 2 * HOLD)));
      lvl = ~lvl;
    end

    check_eq("queue_drained", exp_q.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
